// File: rtl/regfile_onehot_wr_if.sv
// Bus bundle for regfile_onehot_wr: one-hot write port, two read ports and status.
//
// Write handshake: ctrl_writeEnable is the only request qualifier. There is no ready;
// the register file samples the request on every rising clock edge, so a request is
// consumed in the same cycle it is presented. wr_onehot and data_writeReg are don't-care
// while ctrl_writeEnable is low. Reads carry no handshake: data follows the address
// combinationally.
interface regfile_onehot_wr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  ctrl_writeEnable;
    logic [NUM_REGS-1:0]   wr_onehot;
    logic [DATA_WIDTH-1:0] data_writeReg;
    logic [ADDR_WIDTH-1:0] ctrl_readRegA;
    logic [ADDR_WIDTH-1:0] ctrl_readRegB;
    logic [DATA_WIDTH-1:0] data_readRegA;
    logic [DATA_WIDTH-1:0] data_readRegB;
    logic                  wr_error;
    logic [15:0]           wr_count;

    // Pipeline side: issues writes and read addresses, consumes read data and status
    modport master (
        output ctrl_writeEnable, wr_onehot, data_writeReg, ctrl_readRegA, ctrl_readRegB,
        input  data_readRegA, data_readRegB, wr_error, wr_count
    );

    // Register file side
    modport slave (
        input  ctrl_writeEnable, wr_onehot, data_writeReg, ctrl_readRegA, ctrl_readRegB,
        output data_readRegA, data_readRegB, wr_error, wr_count
    );
endinterface

// File: rtl/regfile_onehot_wr.sv
// CPU integer register file with a one-hot write select (fed straight from the
// 5-to-32 write-address decoder) and two combinational read ports.
// r0 reads as zero and ignores writes. A multi-hot select under write enable is
// dropped and latches a sticky wr_error. wr_count counts committed writes and
// saturates at 16'hFFFF.
// Optional feature: define REGFILE_WRITE_BYPASS_EN to forward a valid same-cycle
// write onto any read port addressing the destination register.
module regfile_onehot_wr #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic                clock,
    input logic                reset_n,
    regfile_onehot_wr_if.slave bus
);

    logic [1:0]            rst_sync;
    logic                  rst_int_n;
    logic [NUM_REGS-1:0]   sel;
    logic                  sel_any;
    logic                  sel_multi;
    logic                  wr_commit;
    logic                  wr_multi;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  error_q;
    logic [15:0]           count_q;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    // Reset asserts immediately but releases two clock edges after reset_n rises
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // Select qualification. x & (x-1) clears the lowest set bit, so a nonzero result
    // means two or more bits are set. Bit 0 selects r0, which never takes a write.
    assign sel       = bus.wr_onehot;
    assign sel_any   = |sel;
    assign sel_multi = |(sel & (sel - NUM_REGS'(1)));
    assign wr_commit = rst_int_n & bus.ctrl_writeEnable & sel_any & ~sel_multi & ~sel[0];
    assign wr_multi  = bus.ctrl_writeEnable & sel_multi;

    // Register array: cleared on reset, one entry loaded per committed write
    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (sel[i]) begin
                    regs[i] <= bus.data_writeReg;
                end
            end
        end
    end

    // Sticky error: set by any enabled multi-hot select, cleared only by reset
    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            error_q <= 1'b0;
        end else if (wr_multi) begin
            error_q <= 1'b1;
        end
    end

    // Committed-write counter, holds at all-ones instead of wrapping
    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            count_q <= '0;
        end else if (wr_commit && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic [ADDR_WIDTH-1:0] wr_index;

    // One-hot to binary; only meaningful when wr_commit is high (exactly one bit set)
    always_comb begin
        wr_index = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel[i]) begin
                wr_index = ADDR_WIDTH'(i);
            end
        end
    end

    // Read ports with writeback forwarding; wr_commit excludes r0 and invalid writes
    always_comb begin
        rd_a = (bus.ctrl_readRegA == '0) ? '0 : regs[bus.ctrl_readRegA];
        rd_b = (bus.ctrl_readRegB == '0) ? '0 : regs[bus.ctrl_readRegB];
        if (wr_commit && (bus.ctrl_readRegA == wr_index)) begin
            rd_a = bus.data_writeReg;
        end
        if (wr_commit && (bus.ctrl_readRegB == wr_index)) begin
            rd_b = bus.data_writeReg;
        end
    end
`else
    // Read ports return array contents; a same-cycle write is seen one cycle later
    always_comb begin
        rd_a = (bus.ctrl_readRegA == '0) ? '0 : regs[bus.ctrl_readRegA];
        rd_b = (bus.ctrl_readRegB == '0) ? '0 : regs[bus.ctrl_readRegB];
    end
`endif

    assign bus.data_readRegA = rd_a;
    assign bus.data_readRegB = rd_b;
    assign bus.wr_error      = error_q;
    assign bus.wr_count      = count_q;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Self-checking bench for regfile_onehot_wr. A behavioural model (array + flag +
// counter + release-edge tracking) predicts every read, error and count value.
module tb_regfile_onehot_wr;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    regfile_onehot_wr_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) bus ();

    regfile_onehot_wr #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Clock / reset
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    logic [DW-1:0] mdl [NR];
    logic          mdl_err;
    logic [15:0]   mdl_cnt;
    int            rel_edges;
    logic [DW-1:0] exp_q [$];

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (reset_n && rel_edges >= 2 && bus.ctrl_writeEnable &&
            $countones(bus.wr_onehot) == 1 && !bus.wr_onehot[0] && bus.wr_onehot[a])
            return bus.data_writeReg;
`endif
        return mdl[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        mdl_err = 1'b0;
        mdl_cnt = '0;
        rel_edges = 0;
    endtask

    // Apply the rules to the inputs seen at a rising edge
    task automatic model_commit();
        if (!reset_n) return;
        if (rel_edges < 2) begin
            rel_edges++;
            return;
        end
        if (!bus.ctrl_writeEnable) return;
        if ($countones(bus.wr_onehot) > 1) begin
            mdl_err = 1'b1;
        end else if ($countones(bus.wr_onehot) == 1 && !bus.wr_onehot[0]) begin
            for (int i = 1; i < NR; i++) if (bus.wr_onehot[i]) mdl[i] = bus.data_writeReg;
            if (mdl_cnt != 16'hFFFF) mdl_cnt++;
        end
    endtask

    // Driver tasks
    task automatic drive(input logic en, input logic [NR-1:0] sel, input logic [DW-1:0] data);
        bus.ctrl_writeEnable = en;
        bus.wr_onehot = sel;
        bus.data_writeReg = data;
    endtask

    task automatic set_reads(input logic [AW-1:0] a, input logic [AW-1:0] b);
        bus.ctrl_readRegA = a;
        bus.ctrl_readRegB = b;
    endtask

    task automatic step();
        @(posedge clock);
        model_commit();
        #1;
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        model_reset();
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
        rel_edges = 0;
    endtask

    task automatic test_reset();
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        drive(1'b0, '0, '0);
        set_reads('0, '0);
        assert_reset();
        #2;
        for (int i = 0; i < NR; i++) begin
            ra = AW'(i);
            rb = AW'(NR - 1 - i);
            set_reads(ra, rb);
            #1;
            n_tests++;
            if (bus.data_readRegA !== '0 || bus.data_readRegB !== '0) begin
                n_fail++;
                $display("FAIL reset_held_read addr=%0d: got A=%h B=%h expected 0", i,
                         bus.data_readRegA, bus.data_readRegB);
            end
        end
        step();
        release_reset();
        repeat (3) step();
        for (int i = 0; i < NR; i++) begin
            ra = AW'(i);
            rb = AW'(NR - 1 - i);
            set_reads(ra, rb);
            #1;
            n_tests++;
            if (bus.data_readRegA !== '0 || bus.data_readRegB !== '0) begin
                n_fail++;
                $display("FAIL reset_released_read addr=%0d: got A=%h B=%h expected 0", i,
                         bus.data_readRegA, bus.data_readRegB);
            end
        end
        n_tests++;
        if (bus.wr_error !== 1'b0 || bus.wr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_status: got err=%b cnt=%0d expected err=0 cnt=0",
                     bus.wr_error, bus.wr_count);
        end
    endtask

    task automatic test_basic_write();
        drive(1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
        step();
        drive(1'b0, '0, '0);
        set_reads(5'd5, 5'd5);
        #1;
        n_tests++;
        if (bus.data_readRegA !== 32'hDEAD_BEEF || bus.data_readRegB !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL basic_write_r5: got A=%h B=%h expected deadbeef",
                     bus.data_readRegA, bus.data_readRegB);
        end
        n_tests++;
        if (bus.wr_count !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_write_count: got %0d expected 1", bus.wr_count);
        end
    endtask

    task automatic test_r0_write();
        drive(1'b1, 32'h0000_0001, 32'hFFFF_FFFF);
        set_reads(5'd0, 5'd0);
        #1;
        n_tests++;
        if (bus.data_readRegA !== '0) begin
            n_fail++;
            $display("FAIL r0_same_cycle: got %h expected 0", bus.data_readRegA);
        end
        step();
        drive(1'b0, '0, '0);
        #1;
        n_tests++;
        if (bus.data_readRegA !== '0 || bus.wr_count !== 16'd1 || bus.wr_error !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_write_dropped: got A=%h cnt=%0d err=%b expected 0/1/0",
                     bus.data_readRegA, bus.wr_count, bus.wr_error);
        end
        // Empty select with enable: no write, no error
        drive(1'b1, '0, 32'h5555_5555);
        step();
        drive(1'b0, '0, '0);
        #1;
        n_tests++;
        if (bus.wr_count !== 16'd1 || bus.wr_error !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_select: got cnt=%0d err=%b expected 1/0", bus.wr_count, bus.wr_error);
        end
    endtask

    task automatic test_same_cycle();
        logic [DW-1:0] exp_now;
        drive(1'b1, 32'h0000_0400, 32'h0000_1111);
        step();
        drive(1'b1, 32'h0000_0400, 32'h0000_A5A5);
        set_reads(5'd10, 5'd10);
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        exp_now = 32'h0000_A5A5;
`else
        exp_now = 32'h0000_1111;
`endif
        n_tests++;
        if (bus.data_readRegA !== exp_now || bus.data_readRegB !== exp_now) begin
            n_fail++;
            $display("FAIL same_cycle_read: got A=%h B=%h expected %h",
                     bus.data_readRegA, bus.data_readRegB, exp_now);
        end
        step();
        drive(1'b0, 32'h0000_0400, 32'h0000_5A5A);
        #1;
        n_tests++;
        if (bus.data_readRegA !== 32'h0000_A5A5) begin
            n_fail++;
            $display("FAIL after_commit_read: got %h expected 0000a5a5", bus.data_readRegA);
        end
        step();
        drive(1'b0, '0, '0);
        #1;
        n_tests++;
        if (bus.data_readRegA !== 32'h0000_A5A5 || bus.wr_count !== mdl_cnt) begin
            n_fail++;
            $display("FAIL disabled_write_ignored: got A=%h cnt=%0d expected 0000a5a5 cnt=%0d",
                     bus.data_readRegA, bus.wr_count, mdl_cnt);
        end
    endtask

    task automatic test_random();
        int kind;
        int b1;
        int b2;
        logic [NR-1:0] sel;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        for (int it = 0; it < 400; it++) begin
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                sel = '0;
            end else if (kind == 1) begin
                b1 = $urandom_range(0, NR - 1);
                b2 = (b1 + $urandom_range(1, NR - 1)) % NR;
                sel = (NR'(1) << b1) | (NR'(1) << b2);
            end else begin
                sel = NR'(1) << $urandom_range(0, NR - 1);
            end
            drive($urandom_range(0, 3) != 0, sel, $urandom);
            set_reads(AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)));
            #1;
            exp_q.push_back(exp_read(bus.ctrl_readRegA));
            exp_q.push_back(exp_read(bus.ctrl_readRegB));
            exp_a = exp_q.pop_front();
            exp_b = exp_q.pop_front();
            n_tests++;
            if (bus.data_readRegA !== exp_a || bus.data_readRegB !== exp_b) begin
                n_fail++;
                $display("FAIL random_read it=%0d: got A=%h B=%h expected A=%h B=%h", it,
                         bus.data_readRegA, bus.data_readRegB, exp_a, exp_b);
            end
            n_tests++;
            if (bus.wr_error !== mdl_err || bus.wr_count !== mdl_cnt) begin
                n_fail++;
                $display("FAIL random_status it=%0d: got err=%b cnt=%0d expected err=%b cnt=%0d",
                         it, bus.wr_error, bus.wr_count, mdl_err, mdl_cnt);
            end
            step();
        end
        drive(1'b0, '0, '0);
    endtask

    task automatic test_multi_hot();
        logic [AW-1:0] r;
        drive(1'b0, '0, '0);
        assert_reset();
        #2;
        release_reset();
        repeat (3) step();
        drive(1'b1, 32'h0000_0002, 32'h0000_0011);
        step();
        drive(1'b1, 32'h0000_0004, 32'h0000_0022);
        step();
        drive(1'b1, 32'h0000_0006, 32'h0000_1234);
        set_reads(5'd1, 5'd2);
        #1;
        n_tests++;
        if (bus.data_readRegA !== 32'h11 || bus.data_readRegB !== 32'h22 || bus.wr_error !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_hot_before_edge: got A=%h B=%h err=%b expected 11/22/0",
                     bus.data_readRegA, bus.data_readRegB, bus.wr_error);
        end
        step();
        drive(1'b0, '0, '0);
        #1;
        n_tests++;
        if (bus.data_readRegA !== 32'h11 || bus.data_readRegB !== 32'h22 || bus.wr_error !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_hot_after_edge: got A=%h B=%h err=%b expected 11/22/1",
                     bus.data_readRegA, bus.data_readRegB, bus.wr_error);
        end
        for (int i = 0; i < 10; i++) begin
            r = AW'($urandom_range(3, NR - 1));
            drive(1'b1, NR'(1) << r, $urandom);
            step();
            drive(1'b0, '0, '0);
            set_reads(r, 5'd1);
            #1;
            n_tests++;
            if (bus.wr_error !== 1'b1 || bus.data_readRegA !== mdl[r]) begin
                n_fail++;
                $display("FAIL error_sticky i=%0d: got err=%b A=%h expected err=1 A=%h", i,
                         bus.wr_error, bus.data_readRegA, mdl[r]);
            end
        end
        n_tests++;
        if (bus.wr_count !== 16'd12) begin
            n_fail++;
            $display("FAIL multi_hot_count: got %0d expected 12", bus.wr_count);
        end
        assert_reset();
        #1;
        n_tests++;
        if (bus.wr_error !== 1'b0 || bus.wr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL error_cleared_by_reset: got err=%b cnt=%0d expected 0/0",
                     bus.wr_error, bus.wr_count);
        end
        release_reset();
        repeat (3) step();
    endtask

    task automatic test_reset_mid_write();
        drive(1'b1, 32'h8000_0000, 32'h0000_0007);
        step();
        drive(1'b1, 32'h8000_0000, 32'h0000_0099);
        set_reads(5'd31, 5'd31);
        #1;
        n_tests++;
        if (bus.data_readRegB !== mdl[31] || mdl[31] !== 32'h7) begin
            n_fail++;
            $display("FAIL r31_before_reset: got %h expected 00000007", bus.data_readRegB);
        end
        assert_reset();
        #1;
        n_tests++;
        if (bus.data_readRegA !== '0 || bus.wr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_cycle: got A=%h cnt=%0d expected 0/0",
                     bus.data_readRegA, bus.wr_count);
        end
        step();
        release_reset();
        step();
        n_tests++;
        if (bus.data_readRegA !== exp_read(5'd31) || bus.data_readRegA !== '0) begin
            n_fail++;
            $display("FAIL release_edge1: got %h expected 0", bus.data_readRegA);
        end
        step();
        n_tests++;
        if (bus.data_readRegA !== exp_read(5'd31) || bus.wr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL release_edge2: got A=%h cnt=%0d expected A=%h cnt=0",
                     bus.data_readRegA, bus.wr_count, exp_read(5'd31));
        end
        step();
        drive(1'b0, '0, '0);
        #1;
        n_tests++;
        if (bus.data_readRegA !== 32'h99 || bus.wr_count !== 16'd1) begin
            n_fail++;
            $display("FAIL write_after_release: got A=%h cnt=%0d expected 99/1",
                     bus.data_readRegA, bus.wr_count);
        end
    endtask

    initial begin
        model_reset();
        drive(1'b0, '0, '0);
        set_reads('0, '0);
        #1;
        test_reset();
        test_basic_write();
        test_r0_write();
        test_same_cycle();
        test_random();
        test_multi_hot();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
